// File: rtl/sliced_compare_sequencer.sv
// Multi-cycle magnitude comparator that scans operands MSB slice first.
// Define SLICED_COMPARE_EARLY_EXIT_EN to finish on the first differing slice.
module sliced_compare_sequencer #(
  parameter int SLICE_W    = 6,
  parameter int NUM_SLICES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] A,
  input  logic [SLICE_W*NUM_SLICES-1:0] B,
  input  logic                          gti,
  input  logic                          lti,
  input  logic                          eqi,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          gto,
  output logic                          lto,
  output logic                          eqo
);

  localparam int W  = SLICE_W * NUM_SLICES;
  localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  localparam logic [IW-1:0] IDX_TOP = IW'(NUM_SLICES - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               dec_q, dec_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [2:0]         ci_q, ci_d;
  logic [2:0]         res_q, res_d;

  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic               slice_ne;
  logic               last;

  always_comb begin
    sa = '0;
    sb = '0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      if (idx_q == IW'(s)) begin
        sa = a_q[s*SLICE_W +: SLICE_W];
        sb = b_q[s*SLICE_W +: SLICE_W];
      end
    end
  end

  assign slice_ne = (sa != sb);
  assign last     = (idx_q == '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    a_d     = a_q;
    b_d     = b_q;
    ci_d    = ci_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          ci_d    = {gti, lti, eqi};
          dec_d   = 1'b0;
          idx_d   = IDX_TOP;
          res_d   = 3'b000;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Only the first differing slice decides; lower ones are ignored.
        if (!dec_q && slice_ne) begin
          dec_d = 1'b1;
          res_d = {(sa > sb), (sa < sb), 1'b0};
        end
        if (last && !dec_q && !slice_ne) begin
          res_d = ci_q;
        end
        if (!last) begin
          idx_d = idx_q - IDX_ONE;
        end
`ifdef SLICED_COMPARE_EARLY_EXIT_EN
        if (last || (!dec_q && slice_ne)) begin
          state_d = S_DONE;
        end
`else
        if (last) begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_TOP;
      dec_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 3'b000;
      res_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ci_q    <= ci_d;
      res_q   <= res_d;
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign out_valid       = (state_q == S_DONE);
  assign {gto, lto, eqo} = res_q;

endmodule

// File: tb/tb_sliced_compare_sequencer.sv
// Directed self-checking bench for sliced_compare_sequencer.
// Expected latencies follow SLICED_COMPARE_EARLY_EXIT_EN when defined.
module tb_sliced_compare_sequencer;

`ifdef SLICED_COMPARE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] A;
  logic [23:0] B;
  logic        gti;
  logic        lti;
  logic        eqi;
  logic        out_valid;
  logic        out_ready;
  logic        gto;
  logic        lto;
  logic        eqo;

  int errors;
  int checks;

  sliced_compare_sequencer #(
    .SLICE_W   (6),
    .NUM_SLICES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .gti      (gti),
    .lti      (lti),
    .eqi      (eqi),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .gto      (gto),
    .lto      (lto),
    .eqo      (eqo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    A         = 24'h800000;
    B         = 24'h000001;
    {gti, lti, eqi} = 3'b100;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if ({gto, lto, eqo} !== 3'b000) begin
      errors++;
      $display("FAIL reset_result: got %b want 000", {gto, lto, eqo});
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_hold: in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic run_req(input string nm, input logic [23:0] a,
                         input logic [23:0] b, input logic [2:0] ci,
                         input logic [2:0] exp_r, input int lat_off,
                         input int lat_on);
    int n;
    int lim;
    int exp_lat;
    exp_lat = EE ? lat_on : lat_off;
    lim = 0;
    while (!in_ready && lim < 20) begin
      step();
      lim++;
    end
    A = a;
    B = b;
    {gti, lti, eqi} = ci;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: in_ready=%b want 1", nm, in_ready);
    end
    step();
    in_valid = 1'b0;
    A = 24'($urandom);
    B = 24'($urandom);
    {gti, lti, eqi} = 3'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: out_valid=%b want 1 (timeout)", nm, out_valid);
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges want %0d", nm, n, exp_lat);
    end
    checks++;
    if ({gto, lto, eqo} !== exp_r) begin
      errors++;
      $display("FAIL %s_result: got %b want %b", nm, {gto, lto, eqo}, exp_r);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b want 1/0",
               nm, in_ready, out_valid);
    end
  endtask

  task automatic test_compare();
    run_req("msb_gt", 24'h800000, 24'h7FFFFF, 3'b000, 3'b100, 4, 1);
    run_req("eq_cascade_lt", 24'h123456, 24'h123456, 3'b010, 3'b010, 4, 4);
    run_req("lsb_lt", 24'h000001, 24'h000002, 3'b100, 3'b010, 4, 4);
    run_req("mid_gt_sticky", 24'h03F000, 24'h03EFFF, 3'b001, 3'b100, 4, 2);
    run_req("eq_cascade_gt", 24'hABCDEF, 24'hABCDEF, 3'b100, 3'b100, 4, 4);
    run_req("eq_cascade_eq", 24'h000000, 24'h000000, 3'b001, 3'b001, 4, 4);
  endtask

  task automatic test_stall();
    int n;
    A = 24'h03F000;
    B = 24'h03EFFF;
    {gti, lti, eqi} = 3'b010;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_valid: out_valid=%b want 1 (timeout)", out_valid);
    end
    A = 24'h000001;
    B = 24'h000002;
    {gti, lti, eqi} = 3'b001;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {gto, lto, eqo} !== 3'b100) begin
        errors++;
        $display("FAIL stall_hold%0d: v=%b rdy=%b res=%b want 1/0/100",
                 k, out_valid, in_ready, {gto, lto, eqo});
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_not_captured: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    A = 24'h000001;
    B = 24'h000002;
    {gti, lti, eqi} = 3'b000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || {gto, lto, eqo} !== 3'b000 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_state: v=%b res=%b rdy=%b want 0/000/1",
               out_valid, {gto, lto, eqo}, in_ready);
    end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_result: got %0d valid cycles want 0", seen);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] res[$];
    int acc_cyc[$];
    int nacc;
    bit acc;
    nacc = 0;
    A = 24'h000001;
    B = 24'h000002;
    {gti, lti, eqi} = 3'b100;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      acc = in_valid && in_ready;
      if (out_valid === 1'b1) res.push_back({gto, lto, eqo});
      if (acc) acc_cyc.push_back(k);
      step();
      if (acc) begin
        nacc++;
        if (nacc == 1) begin
          A = 24'h800000;
          B = 24'h7FFFFF;
          {gti, lti, eqi} = 3'b001;
        end else begin
          in_valid = 1'b0;
          A = 24'h000000;
          B = 24'h000000;
        end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (acc_cyc.size() != 2 ||
        (acc_cyc.size() == 2 && acc_cyc[1] - acc_cyc[0] != 6)) begin
      errors++;
      $display("FAIL b2b_spacing: accepts=%0d gap=%0d want 2/6",
               acc_cyc.size(),
               acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1);
    end
    checks++;
    if (res.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 2", res.size());
    end else if (res[0] !== 3'b010 || res[1] !== 3'b100) begin
      errors++;
      $display("FAIL b2b_order: got %b,%b want 010,100", res[0], res[1]);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    gti       = 1'b0;
    lti       = 1'b0;
    eqi       = 1'b0;
    test_reset();
    test_compare();
    test_stall();
    test_reset_mid_scan();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sliced_compare_sequencer.md
SLICED_COMPARE_SEQUENCER -- requirements
Module: sliced_compare_sequencer

Interface
REQ-001 Parameter SLICE_W, default 6, width of one comparison slice in bits.
REQ-002 Parameter NUM_SLICES, default 4, number of slices per operand; operand width W = SLICE_W*NUM_SLICES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present on A, B, gti, lti, eqi.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 A  input  W  first operand; B  input  W  second operand.
REQ-008 gti, lti, eqi  input  1 each  cascade status from lower-order stage; used only when A == B.
REQ-009 out_valid  output  1  result held on gto/lto/eqo.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 gto, lto, eqo  output  1 each  registered result: A>B, A<B, A==B (cascade-resolved).

Function
REQ-012 The block SHALL implement states IDLE, SCAN, DONE; in_ready SHALL equal (state==IDLE).
REQ-013 In IDLE, in_valid&&in_ready SHALL capture A, B, gti, lti, eqi, clear the decided flag, set slice index to NUM_SLICES-1, and enter SCAN.
REQ-014 In SCAN, step j (j=0 at first SCAN cycle) SHALL compare slice NUM_SLICES-1-j (MSB slice first) as unsigned SLICE_W-bit values.
REQ-015 The first slice with A!=B SHALL set decided and latch gto=(A_slice>B_slice), lto=(A_slice<B_slice), eqo=0; later slices SHALL NOT alter a decided result.
REQ-016 After slice 0 with decided clear, outputs SHALL be the captured gti, lti, eqi passed through unchanged.
REQ-017 DONE SHALL assert out_valid with gto/lto/eqo stable until out_valid&&out_ready, then go to IDLE next cycle.
REQ-018 in_valid SHALL be ignored outside IDLE; captured operands SHALL NOT change during SCAN/DONE.
REQ-019 Request accepted at cycle T: out_valid first high at T+1+NUM_SLICES (early exit disabled).
REQ-020 Throughput: at most one request in flight; minimum request-to-request spacing NUM_SLICES+2 cycles with out_ready held high.
REQ-021 Slice index SHALL count down only; it SHALL never wrap below 0 and SHALL NOT be used after leaving SCAN.

Reset
REQ-022 While rst is high at a rising edge: state=IDLE, out_valid=0, gto=lto=eqo=0, decided=0, slice index=NUM_SLICES-1.
REQ-023 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-024 rst in SCAN or DONE SHALL abandon the request; no result for it SHALL ever appear.
REQ-025 rst SHALL take priority over simultaneous in_valid or out_ready.

Configuration
REQ-026 Macro SLICED_COMPARE_EARLY_EXIT_EN defined: on the first differing slice at step j, the block SHALL enter DONE next cycle; out_valid first high at T+2+j.
REQ-027 Macro undefined: every request SHALL spend exactly NUM_SLICES SCAN cycles regardless of data (constant latency per REQ-019).
REQ-028 Result values SHALL be identical with and without the macro; only latency differs.

Verification
REQ-029 A=0x800000, B=0x7FFFFF, accept at T -> gto=1,lto=0,eqo=0; out_valid at T+5 (macro off), T+2 (macro on).
REQ-030 A=B=0x123456, gti=0,lti=1,eqi=0 -> gto=0,lto=1,eqo=0 at T+5, both builds.
REQ-031 A=0x000001, B=0x000002 -> lto=1, gto=0, eqo=0 at T+5, both builds (difference in slice 0).
REQ-032 Result valid, out_ready=0 for 3 cycles, in_valid=1 with new operands -> outputs stable, in_ready=0, new request not captured; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-033 rst pulsed in second SCAN cycle -> next cycle out_valid=0, gto=lto=eqo=0, in_ready=1; no result ever emitted for that request.
REQ-034 Back-to-back: two requests with out_ready=1 -> second accepted at T+6 (macro off), results in order, no stale data.
